// File: rtl/pipe_skid_stage_pkg.sv
// Shared my86 stage-bundle definitions: field widths, status/opcode constants and the bubble bundle.
package pipe_skid_stage_pkg;

  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned D_WORD_W  = 64;
  localparam int unsigned D_STAGE_W = 148;

  localparam logic [NIBBLE_W-1:0] SAOK  = 4'h1;
  localparam logic [NIBBLE_W-1:0] IHALT = 4'h0;
  localparam logic [NIBBLE_W-1:0] RNONE = 4'hF;

  typedef struct packed {
    logic [NIBBLE_W-1:0] stat;
    logic [NIBBLE_W-1:0] icode;
    logic [NIBBLE_W-1:0] ifun;
    logic [NIBBLE_W-1:0] ra;
    logic [NIBBLE_W-1:0] rb;
    logic [D_WORD_W-1:0] valc;
    logic [D_WORD_W-1:0] valp;
  } stage_bundle_t;

  // Halt bubble with status AOK: downstream sees a harmless no-op stage.
  localparam stage_bundle_t D_BUBBLE = '{
    stat:  SAOK,
    icode: IHALT,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  '0,
    valp:  '0
  };

endpackage

// File: rtl/pipe_skid_stage.sv
// Flow-controlled pipeline stage register with optional 2-entry skid buffer, flush and occupancy.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned          DATA_W     = D_STAGE_W,
  parameter logic [DATA_W-1:0]    BUBBLE_VAL = D_BUBBLE,
  parameter bit                   SKID_EN    = 1'b1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic [1:0]        occ_q, occ_d;
  logic              accept;
  logic              emit;

  // With the skid enabled, ready depends only on state, breaking the backpressure path.
  assign in_ready_o  = SKID_EN ? ~skid_v_q : (~main_v_q | out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign emit        = main_v_q & out_ready_i;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_v_q ? main_d_q : BUBBLE_VAL;
  assign occ_o       = occ_q;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;

    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (SKID_EN) begin
      if (!main_v_q) begin
        if (accept) begin
          main_v_d = 1'b1;
          main_d_d = in_data_i;
        end
      end else if (skid_v_q) begin
        // in_ready_o is low here, so only a drain from SKID into MAIN can happen.
        if (emit) begin
          main_d_d = skid_d_q;
          skid_v_d = 1'b0;
        end
      end else if (emit && accept) begin
        main_d_d = in_data_i;
      end else if (emit) begin
        main_v_d = 1'b0;
      end else if (accept) begin
        skid_v_d = 1'b1;
        skid_d_d = in_data_i;
      end
    end else begin
      skid_v_d = 1'b0;
      if (accept) begin
        main_v_d = 1'b1;
        main_d_d = in_data_i;
      end else if (emit) begin
        main_v_d = 1'b0;
      end
    end

    occ_d = {1'b0, main_v_d} + {1'b0, skid_v_d};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_d_q <= '0;
      skid_d_q <= '0;
      occ_q    <= 2'd0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: both SKID_EN variants against a queue model of the stage contents.
module tb_pipe_skid_stage;

  localparam int unsigned W = 148;
  localparam logic [W-1:0] BUBBLE = {4'h1, 4'h0, 4'h0, 4'hF, 4'hF, 128'h0};

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Instance 1: SKID_EN=1, instance 0: SKID_EN=0
  logic         f1, iv1, ir1, ov1, or1;
  logic [W-1:0] id1, od1;
  logic [1:0]   oc1;
  logic         f0, iv0, ir0, ov0, or0;
  logic [W-1:0] id0, od0;
  logic [1:0]   oc0;

  pipe_skid_stage #(.DATA_W(W), .BUBBLE_VAL(BUBBLE), .SKID_EN(1'b1)) u_skid (
    .clk_i(clk), .rstn_i(rstn), .flush_i(f1), .in_valid_i(iv1), .in_ready_o(ir1),
    .in_data_i(id1), .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1), .occ_o(oc1)
  );

  pipe_skid_stage #(.DATA_W(W), .BUBBLE_VAL(BUBBLE), .SKID_EN(1'b0)) u_noskid (
    .clk_i(clk), .rstn_i(rstn), .flush_i(f0), .in_valid_i(iv0), .in_ready_o(ir0),
    .in_data_i(id0), .out_valid_o(ov0), .out_ready_i(or0), .out_data_o(od0), .occ_o(oc0)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] head(input logic [W-1:0] q[$]);
    return (q.size() > 0) ? q[0] : BUBBLE;
  endfunction

  // Compare every output of both DUTs against the queue model, then advance one clock.
  task automatic cycle();
    logic r1, r0, acc1, acc0, em1, em0;
    #1;
    r1 = (q1.size() < 2);
    r0 = (q0.size() == 0) || or0;
    chk("skid_in_ready", W'(ir1), W'(r1));
    chk("skid_out_valid", W'(ov1), W'(q1.size() > 0));
    chk("skid_out_data", od1, head(q1));
    chk("skid_occ", W'(oc1), W'(q1.size()));
    chk("noskid_in_ready", W'(ir0), W'(r0));
    chk("noskid_out_valid", W'(ov0), W'(q0.size() > 0));
    chk("noskid_out_data", od0, head(q0));
    chk("noskid_occ", W'(oc0), W'(q0.size()));
    acc1 = iv1 & r1;
    acc0 = iv0 & r0;
    em1  = (q1.size() > 0) & or1;
    em0  = (q0.size() > 0) & or0;
    @(posedge clk);
    if (f1) q1 = {};
    else begin
      if (em1) void'(q1.pop_front());
      if (acc1) q1.push_back(id1);
    end
    if (f0) q0 = {};
    else begin
      if (em0) void'(q0.pop_front());
      if (acc0) q0.push_back(id0);
    end
    @(negedge clk);
  endtask

  task automatic idle_all();
    f1 = 0; iv1 = 0; or1 = 0; id1 = 'x;
    f0 = 0; iv0 = 0; or0 = 0; id0 = 'x;
  endtask

  function automatic logic [W-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    idle_all();
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    cycle();

    // Fill both entries, then reset mid-beat.
    iv1 = 1; id1 = W'(16'h1111); or1 = 0;
    cycle();
    id1 = W'(16'h2222);
    cycle();
    chk("pre_reset_occ", W'(oc1), W'(2));
    id1 = W'(16'h3333); or1 = 1;
    rstn = 0;
    #1;
    chk("reset_out_valid", W'(ov1), W'(0));
    chk("reset_out_data", od1, BUBBLE);
    chk("reset_occ", W'(oc1), W'(0));
    chk("reset_in_ready", W'(ir1), W'(1));
    q1 = {}; q0 = {};
    idle_all();
    @(negedge clk);
    rstn = 1;
    cycle();

    // Streaming 1..8 with downstream always ready.
    or1 = 1; iv1 = 1;
    for (int i = 1; i <= 8; i++) begin
      id1 = W'(i);
      cycle();
      chk("stream_data", od1, W'(i));
      chk("stream_occ", W'(oc1), W'(1));
    end
    iv1 = 0; id1 = 'x;
    cycle();
    chk("stream_drained", W'(ov1), W'(0));

    // Backpressure: two beats pile up, then drain in order.
    or1 = 0; iv1 = 1; id1 = W'(8'hA);
    cycle();
    id1 = W'(8'hB);
    cycle();
    iv1 = 0; id1 = 'x;
    #1;
    chk("bp_occ", W'(oc1), W'(2));
    chk("bp_in_ready", W'(ir1), W'(0));
    or1 = 1;
    chk("bp_first", od1, W'(8'hA));
    cycle();
    chk("bp_second", od1, W'(8'hB));
    cycle();
    chk("bp_empty", W'(ov1), W'(0));

    // Flush with a full stage and an incoming beat.
    or1 = 0; iv1 = 1; id1 = W'(8'hA);
    cycle();
    id1 = W'(8'hB);
    cycle();
    f1 = 1; id1 = W'(8'hC);
    cycle();
    chk("flush_occ", W'(oc1), W'(0));
    chk("flush_data", od1, BUBBLE);
    f1 = 0; iv1 = 0; id1 = 'x; or1 = 1;
    cycle();
    chk("flush_beat_absent", W'(ov1), W'(0));
    or1 = 0;

    // Single-entry variant: ready follows out_ready_i combinationally.
    iv0 = 1; id0 = W'(8'h5); or0 = 0;
    cycle();
    iv0 = 0; id0 = 'x;
    #1;
    chk("noskid_full_ready", W'(ir0), W'(0));
    or0 = 1;
    #1;
    chk("noskid_release_ready", W'(ir0), W'(1));
    chk("noskid_hold_data", od0, W'(8'h5));
    iv0 = 1; id0 = W'(8'h6);
    cycle();
    chk("noskid_passthru", od0, W'(8'h6));
    chk("noskid_occ", W'(oc0), W'(1));
    idle_all();
    cycle();

    // Random valid/ready/flush on both variants.
    for (int c = 0; c < 10000; c++) begin
      iv1 = ($urandom_range(99) < 60);
      or1 = ($urandom_range(99) < 60);
      f1  = ($urandom_range(99) < 2);
      id1 = iv1 ? rnd_data() : 'x;
      iv0 = ($urandom_range(99) < 60);
      or0 = ($urandom_range(99) < 60);
      f0  = ($urandom_range(99) < 2);
      id0 = iv0 ? rnd_data() : 'x;
      cycle();
    end
    idle_all();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
